// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment capture path: bus width, DP position
// and the active-low hex glyph table (bit7 = dp, held high in the table).
package seg_pkg;

  localparam int SEG_W  = 8;
  localparam int DP_BIT = 7;

  // Entry k is the active-low pattern that displays hex digit k.
  localparam logic [15:0][SEG_W-1:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic       match;
    logic [3:0] nibble;
  } glyph_t;

endpackage

// File: rtl/seg_scan_capture_if.sv
// Pin-side scan lines into the capture block plus its decoded results.
interface seg_scan_capture_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [SEG_W-1:0]        seg_in;
  logic [NUM_DIGITS-1:0]   anode_in;
  logic [4*NUM_DIGITS-1:0] hex_value;
  logic [NUM_DIGITS-1:0]   dp_value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    invalid_pattern;
  logic                    anode_err;
  logic                    stale;

  // master drives the display lines and observes results
  modport master (
    output seg_in, anode_in,
    input  hex_value, dp_value, digit_valid, frame_done,
           invalid_pattern, anode_err, stale
  );

  // slave is the capture block
  modport slave (
    input  seg_in, anode_in,
    output hex_value, dp_value, digit_valid, frame_done,
           invalid_pattern, anode_err, stale
  );

endinterface

// File: rtl/seg_glyph_decode.sv
// Reverse glyph lookup: active-low a..g pattern to hex nibble.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output glyph_t     glyph
);

  // Table search; glyphs are unique so at most one entry matches.
  always_comb begin
    glyph = '0;
    for (int k = 0; k < 16; k++) begin
      if (seg == GLYPH[k][6:0]) begin
        glyph.match  = 1'b1;
        glyph.nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment drive. Synchronises the scan
// lines, waits for each dwell to settle, captures one pattern per dwell
// and decodes it back to a hex nibble + dp per digit.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_capture_if.slave bus
);

  localparam int SW = SEG_W + NUM_DIGITS;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_SETTLE  = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [SW-1:0]         sync1, sync2, prev;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [NUM_DIGITS-1:0] cap_anode;
  logic [SEG_W-1:0]      cap_seg;
  logic                  cap_en, one_cold, blank, do_cap, do_err;
  logic [NUM_DIGITS-1:0] sel;
  glyph_t                glyph;

  logic [NUM_DIGITS-1:0][3:0] hex_q;
  logic [NUM_DIGITS-1:0]      dp_q, dv_q, seen;
  logic                       frame_q, inv_q, aerr_q;
  logic [TW-1:0]              tcnt;

  // Two-flop synchroniser; idle bus level (all high) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus.anode_in, bus.seg_in};
      sync2 <= sync1;
    end
  end

  // Dwell filter: count identical samples, capture once, then hold until the lines move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SETTLE;
      cnt   <= '0;
      prev  <= '1;
    end else begin
      prev <= sync2;
      case (state)
        ST_SETTLE: begin
          if (sync2 != prev) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(STABLE_CYCLES - 2)) state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          cnt   <= '0;
          // a change landing on the capture cycle starts the next dwell directly
          state <= (sync2 != prev) ? ST_SETTLE : ST_HOLD;
        end
        ST_HOLD: begin
          if (sync2 != prev) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // prev holds the settled value while in CAPTURE
  assign cap_anode = prev[SW-1:SEG_W];
  assign cap_seg   = prev[SEG_W-1:0];
  assign cap_en    = (state == ST_CAPTURE);
  assign one_cold  = $onehot(~cap_anode);
  assign blank     = &cap_anode;
  assign do_cap    = cap_en && one_cold;
  assign do_err    = cap_en && !one_cold && !blank;
  assign sel       = do_cap ? ~cap_anode : '0;

  seg_glyph_decode u_dec (
    .seg   (cap_seg[6:0]),
    .glyph (glyph)
  );

  // Per-digit result registers; an unmatched glyph keeps the old nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= '0;
      dp_q  <= '0;
      dv_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          if (glyph.match) hex_q[i] <= glyph.nibble;
          dv_q[i] <= glyph.match;
          dp_q[i] <= ~cap_seg[DP_BIT];
        end
      end
    end
  end

  // Event pulses and frame tracking; a capture on the clear cycle opens the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
      inv_q   <= 1'b0;
      aerr_q  <= 1'b0;
      seen    <= '0;
    end else begin
      frame_q <= &seen;
      inv_q   <= do_cap && !glyph.match;
      aerr_q  <= do_err;
      seen    <= (&seen) ? sel : (seen | sel);
    end
  end

  // Saturating idle timer, cleared by any capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (do_cap) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign bus.hex_value       = hex_q;
  assign bus.dp_value        = dp_q;
  assign bus.digit_valid     = dv_q;
  assign bus.frame_done      = frame_q;
  assign bus.invalid_pattern = inv_q;
  assign bus.anode_err       = aerr_q;
  assign bus.stale           = (tcnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench: each driven dwell is turned into expected events by a
// dwell-level model; a negedge monitor compares every cycle.
module tb_seg_scan_capture;
  import seg_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_capture_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  dv;
    bit          inv;
    bit          aerr;
    bit          fd;
    bit          cap;
  } ev_t;

  ev_t q[$];
  int checks = 0;
  int failures = 0;

  byte unsigned glyphs[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // reference state, advanced one dwell at a time
  logic [15:0] m_hex;
  logic [3:0]  m_dp, m_dv, m_seen;
  logic [11:0] last_pin;
  int          last_cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input bit cap, input bit inv, input bit aerr, input bit fd);
    ev_t e;
    e.cyc = c; e.hex = m_hex; e.dp = m_dp; e.dv = m_dv;
    e.cap = cap; e.inv = inv; e.aerr = aerr; e.fd = fd;
    q.push_back(e);
  endtask

  // Hold (a,s) on the pins for len cycles. A dwell of at least SC cycles
  // yields one capture 2 (sync) + SC (filter) + 1 cycles after it starts.
  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int len);
    int t, idx;
    bit hit;
    logic [7:0] g;
    last_pin = {a, s};
    t = cyc + 2 + SC + 1;
    if (len >= SC && a != 4'hF) begin
      if ($countones(~a) == 1) begin
        idx = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) idx = i;
        hit = 0;
        for (int k = 0; k < 16; k++) begin
          g = glyphs[k];
          if (s[6:0] == g[6:0]) begin hit = 1; m_hex[4*idx +: 4] = 4'(k); end
        end
        m_dv[idx] = hit;
        m_dp[idx] = ~s[7];
        m_seen[idx] = 1'b1;
        push(t, 1, !hit, 0, 0);
        if (m_seen == 4'hF) begin
          push(t + 1, 0, 0, 0, 1);
          m_seen = 4'h0;
        end
      end else begin
        push(t, 0, 0, 1, 0);
      end
    end
    bus.anode_in = a;
    bus.seg_in = s;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    q.delete();
    m_hex = '0; m_dp = '0; m_dv = '0; m_seen = '0;
    bus.anode_in = '1;
    bus.seg_in = '1;
    last_pin = '1;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_cap = cyc;
  endtask

  // Monitor: pops the event due this cycle and checks every output.
  initial begin
    logic [15:0] c_hex;
    logic [3:0]  c_dp, c_dv;
    bit          e_inv, e_aerr, e_fd, e_stale;
    ev_t         e;
    c_hex = '0; c_dp = '0; c_dv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c_hex = '0; c_dp = '0; c_dv = '0;
        chk("rst_outputs", {bus.hex_value, bus.dp_value, bus.digit_valid}, 32'h0);
        chk("rst_flags", {bus.frame_done, bus.invalid_pattern, bus.anode_err, bus.stale}, 32'h0);
      end else begin
        e_inv = 0; e_aerr = 0; e_fd = 0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("event_overdue", 32'(e.cyc), 32'(cyc));
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          c_hex = e.hex; c_dp = e.dp; c_dv = e.dv;
          e_inv = e.inv; e_aerr = e.aerr; e_fd = e.fd;
          if (e.cap) last_cap = cyc;
        end
        e_stale = (cyc - last_cap) >= TO;
        chk("hex_value", bus.hex_value, c_hex);
        chk("dp_value", bus.dp_value, c_dp);
        chk("digit_valid", bus.digit_valid, c_dv);
        chk("frame_done", bus.frame_done, e_fd);
        chk("invalid_pattern", bus.invalid_pattern, e_inv);
        chk("anode_err", bus.anode_err, e_aerr);
        chk("stale", bus.stale, e_stale);
      end
    end
  end

  initial begin
    logic [3:0] a;
    logic [7:0] s;
    int r, x;
    bus.anode_in = '1;
    bus.seg_in = '1;
    last_cap = 0;
    @(posedge clk); #1;
    do_reset(3);
    drive(4'hF, 8'hFF, 5);

    // single digit 0, dp off
    drive(4'hE, 8'hC0, 10);
    chk("t1_hex0", bus.hex_value[3:0], 4'h0);
    chk("t1_dv0", bus.digit_valid[0], 1'b1);
    chk("t1_dp0", bus.dp_value[0], 1'b0);
    drive(4'hF, 8'hFF, 6);

    // too-short dwell on digit 1
    drive(4'hD, 8'h99, 2);
    drive(4'hB, 8'h99, 10);
    chk("t2_dv1", bus.digit_valid[1], 1'b0);
    chk("t2_dv2", bus.digit_valid[2], 1'b1);

    // full frame 4321 with dp on digit 3
    do_reset(3);
    drive(4'hE, 8'hF9, 10);
    drive(4'hD, 8'hA4, 10);
    drive(4'hB, 8'hB0, 10);
    drive(4'h7, 8'h19, 10);
    chk("t3_hex", bus.hex_value, 16'h4321);
    chk("t3_dp", bus.dp_value, 4'b1000);

    // blank glyph keeps nibble, clears valid
    drive(4'hD, 8'hFF, 10);
    chk("t4_hex1", bus.hex_value[7:4], 4'h2);
    chk("t4_dv1", bus.digit_valid[1], 1'b0);

    // two anodes low
    drive(4'hC, 8'hC0, 10);
    chk("t5_hex", bus.hex_value, 16'h4321);

    // stale after idle, cleared by capture, then reset mid-frame
    drive(4'hF, 8'hFF, TO + 10);
    chk("t6_stale", bus.stale, 1'b1);
    drive(4'hE, 8'h80, 10);
    chk("t6_unstale", bus.stale, 1'b0);
    drive(4'hD, 8'h92, 10);
    drive(4'hB, 8'h82, 2);
    do_reset(3);
    chk("t6_rst_hex", bus.hex_value, 16'h0);
    chk("t6_rst_dv", bus.digit_valid, 4'h0);
    drive(4'hE, 8'hF8, 8);
    drive(4'hD, 8'h80, 8);
    drive(4'hB, 8'h90, 8);
    drive(4'h7, 8'h88, 8);
    chk("t6_hex", bus.hex_value, 16'hA987);

    // randomized scan traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      x = $urandom_range(0, 3);
      if (r < 60) a = ~(4'b0001 << x);
      else if (r < 75) a = 4'hF;
      else a = ~((4'b0001 << x) | (4'b0001 << ((x + 1 + $urandom_range(0, 2)) % 4)));
      if ($urandom_range(0, 99) < 70) begin
        s = glyphs[$urandom_range(0, 15)];
        if ($urandom_range(0, 1) == 1) s[7] = 1'b0;
      end else begin
        s = 8'($urandom);
      end
      if ({a, s} == last_pin) s = s ^ 8'h01;
      drive(a, s, $urandom_range(1, 12));
      if (n == 100) do_reset(2);
    end

    drive(4'hF, 8'hFF, 20);
    for (int w = 0; w < 50 && q.size() > 0; w++) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
